// File: rtl/video_mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : video_mem_arbiter_if
// Purpose  : Requester handshakes, scoreboard bitmap and memory-side control
//            bundle for the video object memory arbiter.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface video_mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 144
);
  // transform write-back
  logic                 wb_req;
  logic [ADDR_W-1:0]    wb_addr;
  logic [DATA_W-1:0]    wb_data;
  logic                 wb_gnt;
  // transform fetch
  logic                 rd_req;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_gnt;
  logic                 rd_valid;
  // CPU loadback
  logic                 ldb_req;
  logic [ADDR_W-1:0]    ldb_addr;
  logic                 ldb_gnt;
  logic                 ldb_done;
  // clip-stage read
  logic                 clip_req;
  logic [ADDR_W-1:0]    clip_addr;
  logic                 clip_gnt;
  logic                 clip_valid;
  // scoreboard
  logic                 frame_clr;
  logic [2**ADDR_W-1:0] obj_valid;
  // memory control
  logic [ADDR_W-1:0]    mem_mat_addr;
  logic [DATA_W-1:0]    mem_mat_obj_in;
  logic                 mem_mat_wr_en;
  logic                 mem_mat_rd_en;
  logic                 mem_loadback;
  logic [ADDR_W-1:0]    mem_clip_addr;
  logic                 mem_clip_rd_en;

  // Arbiter side
  modport slave (
    input  wb_req, wb_addr, wb_data, rd_req, rd_addr, ldb_req, ldb_addr,
           clip_req, clip_addr, frame_clr,
    output wb_gnt, rd_gnt, rd_valid, ldb_gnt, ldb_done, clip_gnt, clip_valid,
           obj_valid, mem_mat_addr, mem_mat_obj_in, mem_mat_wr_en,
           mem_mat_rd_en, mem_loadback, mem_clip_addr, mem_clip_rd_en
  );

  // Requester / memory side
  modport master (
    output wb_req, wb_addr, wb_data, rd_req, rd_addr, ldb_req, ldb_addr,
           clip_req, clip_addr, frame_clr,
    input  wb_gnt, rd_gnt, rd_valid, ldb_gnt, ldb_done, clip_gnt, clip_valid,
           obj_valid, mem_mat_addr, mem_mat_obj_in, mem_mat_wr_en,
           mem_mat_rd_en, mem_loadback, mem_clip_addr, mem_clip_rd_en
  );
endinterface
`default_nettype wire

// File: rtl/video_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : video_mem_arbiter
// Purpose  : Round-robin sharing of the video object memory mat port between
//            transform write-back, transform fetch and CPU loadback, plus a
//            scoreboard-gated clip read port. All memory controls registered.
// Options  : VMEM_ARB_STATS_EN adds saturating stall counters stall_mat and
//            stall_clip.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module video_mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 144
) (
  input  wire                clk,
  input  wire                rst,
  video_mem_arbiter_if.slave bus
`ifdef VMEM_ARB_STATS_EN
  ,
  output logic [15:0]        stall_mat,
  output logic [15:0]        stall_clip
`endif
);

  localparam int c_DEPTH = 2**ADDR_W;

  // Round-robin pointer: which mat requester currently has top priority
  typedef enum logic [1:0] {
    PRI_WB  = 2'd0,
    PRI_RD  = 2'd1,
    PRI_LDB = 2'd2
  } pri_t;

  pri_t                r_ptr;
  pri_t                w_ptr_nxt;
  logic                w_gnt_wb;
  logic                w_gnt_rd;
  logic                w_gnt_ldb;
  logic                w_gnt_clip;
  logic [c_DEPTH-1:0]  r_obj_valid;
  logic [c_DEPTH-1:0]  w_obj_nxt;

  logic [ADDR_W-1:0]   r_mat_addr;
  logic [DATA_W-1:0]   r_mat_obj_in;
  logic                r_mat_wr_en;
  logic                r_mat_rd_en;
  logic                r_loadback;
  logic                r_rd_valid;
  logic                r_ldb_done;
  logic [ADDR_W-1:0]   r_clip_addr;
  logic                r_clip_rd_en;
  logic                r_clip_valid;

  // Pointer register; returns to wb-first on reset
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= PRI_WB;
    else     r_ptr <= w_ptr_nxt;
  end

  // Mat grant selection in rotating priority order and pointer advance
  always_comb begin
    w_gnt_wb  = 1'b0;
    w_gnt_rd  = 1'b0;
    w_gnt_ldb = 1'b0;
    w_ptr_nxt = r_ptr;
    if (!rst) begin
      case (r_ptr)
        PRI_RD: begin
          if      (bus.rd_req)  w_gnt_rd  = 1'b1;
          else if (bus.ldb_req) w_gnt_ldb = 1'b1;
          else if (bus.wb_req)  w_gnt_wb  = 1'b1;
        end
        PRI_LDB: begin
          if      (bus.ldb_req) w_gnt_ldb = 1'b1;
          else if (bus.wb_req)  w_gnt_wb  = 1'b1;
          else if (bus.rd_req)  w_gnt_rd  = 1'b1;
        end
        default: begin
          if      (bus.wb_req)  w_gnt_wb  = 1'b1;
          else if (bus.rd_req)  w_gnt_rd  = 1'b1;
          else if (bus.ldb_req) w_gnt_ldb = 1'b1;
        end
      endcase
      // Priority moves to the requester after the winner
      if      (w_gnt_wb)  w_ptr_nxt = PRI_RD;
      else if (w_gnt_rd)  w_ptr_nxt = PRI_LDB;
      else if (w_gnt_ldb) w_ptr_nxt = PRI_WB;
    end
  end

  // Clip read only proceeds once its entry has been written; frame_clr blocks it
  always_comb begin
    w_gnt_clip = 1'b0;
    if (!rst && !bus.frame_clr)
      w_gnt_clip = bus.clip_req & r_obj_valid[bus.clip_addr];
  end

  // Scoreboard update: clip consume, then wb set (set wins), frame_clr overrides
  always_comb begin
    w_obj_nxt = r_obj_valid;
    if (w_gnt_clip) w_obj_nxt[bus.clip_addr] = 1'b0;
    if (w_gnt_wb)   w_obj_nxt[bus.wb_addr]   = 1'b1;
    if (bus.frame_clr) w_obj_nxt = '0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) r_obj_valid <= '0;
    else     r_obj_valid <= w_obj_nxt;
  end

  // Mat-port issue registers and delayed completion strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mat_addr   <= '0;
      r_mat_obj_in <= '0;
      r_mat_wr_en  <= 1'b0;
      r_mat_rd_en  <= 1'b0;
      r_loadback   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_ldb_done   <= 1'b0;
    end else begin
      r_mat_wr_en <= w_gnt_wb;
      r_mat_rd_en <= w_gnt_rd;
      r_loadback  <= w_gnt_ldb;
      r_rd_valid  <= r_mat_rd_en;
      r_ldb_done  <= r_loadback;
      if (w_gnt_wb) begin
        r_mat_addr   <= bus.wb_addr;
        r_mat_obj_in <= bus.wb_data;
      end else if (w_gnt_rd) begin
        r_mat_addr   <= bus.rd_addr;
      end else if (w_gnt_ldb) begin
        r_mat_addr   <= bus.ldb_addr;
      end
    end
  end

  // Clip-port issue register and read-valid strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clip_addr  <= '0;
      r_clip_rd_en <= 1'b0;
      r_clip_valid <= 1'b0;
    end else begin
      r_clip_rd_en <= w_gnt_clip;
      r_clip_valid <= r_clip_rd_en;
      if (w_gnt_clip) r_clip_addr <= bus.clip_addr;
    end
  end

  assign bus.wb_gnt         = w_gnt_wb;
  assign bus.rd_gnt         = w_gnt_rd;
  assign bus.ldb_gnt        = w_gnt_ldb;
  assign bus.clip_gnt       = w_gnt_clip;
  assign bus.rd_valid       = r_rd_valid;
  assign bus.ldb_done       = r_ldb_done;
  assign bus.clip_valid     = r_clip_valid;
  assign bus.obj_valid      = r_obj_valid;
  assign bus.mem_mat_addr   = r_mat_addr;
  assign bus.mem_mat_obj_in = r_mat_obj_in;
  assign bus.mem_mat_wr_en  = r_mat_wr_en;
  assign bus.mem_mat_rd_en  = r_mat_rd_en;
  assign bus.mem_loadback   = r_loadback;
  assign bus.mem_clip_addr  = r_clip_addr;
  assign bus.mem_clip_rd_en = r_clip_rd_en;

`ifdef VMEM_ARB_STATS_EN
  logic        w_mat_stall;
  logic        w_clip_stall;
  logic [15:0] r_stall_mat;
  logic [15:0] r_stall_clip;

  // A mat stall is any pending mat requester that lost this cycle
  assign w_mat_stall  = |({bus.wb_req, bus.rd_req, bus.ldb_req} &
                          ~{w_gnt_wb, w_gnt_rd, w_gnt_ldb});
  assign w_clip_stall = bus.clip_req & ~w_gnt_clip;

  // Saturating stall counters, cleared per frame
  always_ff @(posedge clk) begin
    if (rst || bus.frame_clr) begin
      r_stall_mat  <= '0;
      r_stall_clip <= '0;
    end else begin
      if (w_mat_stall && (r_stall_mat != 16'hFFFF))
        r_stall_mat <= r_stall_mat + 16'd1;
      if (w_clip_stall && (r_stall_clip != 16'hFFFF))
        r_stall_clip <= r_stall_clip + 16'd1;
    end
  end

  assign stall_mat  = r_stall_mat;
  assign stall_clip = r_stall_clip;
`endif

endmodule
`default_nettype wire

// File: doc/video_mem_arbiter.md
Name: video_mem_arbiter

Overview:
Sequences and shares the 32-entry x 144-bit video object memory between four requesters:
- transform write-back (wb)
- transform fetch (rd)
- CPU loadback (ldb)
- clip-stage read (clip)

wb, rd and ldb share the memory's single mat-side address/control port under round-robin arbitration. clip uses the memory's independent clip port, gated by a per-entry object-valid scoreboard. The block sits between the transform/clip/CPU-interface units and the video memory, and drives all of the memory's control inputs through registers.

Parameters:
ADDR_W, 5, object address width (memory depth 2^ADDR_W = 32)
DATA_W, 144, object width

Ports:
clk  in  1  system clock
rst  in  1  reset
wb_req  in  1  transform write request, held until wb_gnt
wb_addr  in  ADDR_W  write address
wb_data  in  DATA_W  write object
wb_gnt  out  1  write granted this cycle
rd_req  in  1  transform fetch request, held until rd_gnt
rd_addr  in  ADDR_W  fetch address
rd_gnt  out  1  fetch granted this cycle
rd_valid  out  1  memory mat_obj_out is valid this cycle
ldb_req  in  1  CPU loadback request, held until ldb_gnt
ldb_addr  in  ADDR_W  loadback address
ldb_gnt  out  1  loadback granted this cycle
ldb_done  out  1  loadback coordinates are valid at the memory outputs
clip_req  in  1  clip read request, held until clip_gnt
clip_addr  in  ADDR_W  clip address
clip_gnt  out  1  clip read granted this cycle
clip_valid  out  1  memory clip_obj_out is valid this cycle
frame_clr  in  1  clears the whole scoreboard
obj_valid  out  2^ADDR_W  scoreboard bitmap
mem_mat_addr  out  ADDR_W  to memory mat_addr
mem_mat_obj_in  out  DATA_W  to memory mat_obj_in
mem_mat_wr_en  out  1  to memory mat_wr_en
mem_mat_rd_en  out  1  to memory mat_rd_en
mem_loadback  out  1  to memory loadback
mem_clip_addr  out  ADDR_W  to memory clip_addr
mem_clip_rd_en  out  1  to memory clip_rd_en

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - All mem_* outputs, rd_valid, ldb_done, clip_valid and obj_valid are 0.
  - Round-robin pointer is reset to 0 (wb has highest priority first).
- Grants:
  - wb_gnt, rd_gnt, ldb_gnt and clip_gnt are combinational from the requests and internal state.
  - All grants are forced to 0 while rst=1.
  - A requester holds req and addr/data stable until its grant is seen. It may deassert req next cycle or present a new request.
- Mat-port arbitration:
  - At most one of wb, rd, ldb is granted per cycle.
  - Round-robin order is wb -> rd -> ldb.
  - The 2-bit pointer selects the highest-priority requester and advances to the one after the winner. It holds when nothing is granted.
  - Two continuously asserted requesters alternate every cycle. No requester waits more than 2 cycles behind others.
- Issue registers. At the edge after a grant in cycle N:
  - wb: mem_mat_addr<=wb_addr, mem_mat_obj_in<=wb_data, mem_mat_wr_en=1 for one cycle (N+1).
  - rd: mem_mat_addr<=rd_addr, mem_mat_rd_en=1 in N+1; rd_valid=1 in N+2.
  - ldb: mem_mat_addr<=ldb_addr, mem_loadback=1 in N+1; ldb_done=1 in N+2, aligned with the memory's cpu_wr_en.
  - Enables are 0 in any cycle with no grant. mem_mat_addr and mem_mat_obj_in hold their last value.
- Scoreboard:
  - obj_valid[wb_addr] is set at the edge ending the wb grant cycle.
  - clip_gnt = clip_req & obj_valid[clip_addr]. A clip request to an unwritten entry stalls indefinitely.
  - On clip grant, obj_valid[clip_addr] is cleared (entry consumed); mem_clip_addr/mem_clip_rd_en are issued in N+1; clip_valid=1 in N+2.
  - The clip read therefore reaches memory at least one edge after the write completes. No read-during-write of a stale object is possible.
- Simultaneous events on the scoreboard:
  - wb grant and clip grant to the same address in one cycle: set wins, bit ends at 1. This is legal; the clip reads the prior object, which is the producer's responsibility.
  - frame_clr: all bits are 0 next edge and clip_gnt is forced to 0 that cycle. frame_clr has priority over a same-cycle wb set.
- rd and ldb ignore the scoreboard.
- Reset mid-operation: in-flight rd_valid, ldb_done and clip_valid pulses are squashed. The scoreboard is cleared and the pointer returns to 0.

Optional Feature:
Macro VMEM_ARB_STATS_EN.
- Defined: adds outputs stall_mat (16 bits) and stall_clip (16 bits), saturating counters.
  - stall_mat increments each cycle any mat-side request is pending and not granted.
  - stall_clip increments each cycle clip_req=1 and clip_gnt=0.
  - Both counters are cleared by rst and by frame_clr.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold rst for 3 cycles while all reqs=1 -> all grants 0, obj_valid=0; after release the first grant is wb.
2. wb_req addr 5 data 0xA5..A5 in cycle 0 -> wb_gnt cycle 0, mem_mat_wr_en=1 and addr 5 in cycle 1, obj_valid[5]=1 from cycle 1.
3. wb, rd, ldb all held high for 6 cycles -> grant order wb, rd, ldb, wb, rd, ldb; rd_valid 2 cycles after each rd_gnt, ldb_done 2 cycles after each ldb_gnt.
4. clip_req addr 9 with obj_valid[9]=0 -> no grant; wb to 9 at cycle 4 -> clip_gnt cycle 5, clip_valid cycle 7, obj_valid[9]=0 from cycle 6.
5. frame_clr while clip_req pending on a valid entry and wb to 3 granted -> clip_gnt 0, obj_valid all 0 next cycle including bit 3.
6. With VMEM_ARB_STATS_EN: clip_req on an empty entry for 70000 cycles -> stall_clip saturates at 0xFFFF.
